rtc_read_sequencer: RTL and testbench

RTC_READ_SEQUENCER -- requirements
Module: rtc_read_sequencer

---
 rtl/rtc_read_sequencer.sv | 119 +++++++++++
 tb/tb_rtc_read_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_read_sequencer.sv
// Walks the nine RTC time/timer registers over a simple req/ack bus and strobes
// each returned byte into a one-hot addressed register bank, on demand or periodically.
module rtc_read_sequencer #(
  parameter int REFRESH_CYCLES = 1000000,
  parameter int TIMEOUT        = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       auto_en,
  output logic       bus_req,
  output logic [7:0] bus_addr,
  input  logic       bus_ack,
  input  logic [7:0] bus_rdata,
  output logic [8:0] en,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, WRITE, DONE, ERR} state_t;

  state_t          state;
  logic [3:0]      idx;
  logic [RW-1:0]   refresh_cnt;
  logic [TW-1:0]   timeout_cnt;
  logic            tick;

  function automatic logic [7:0] reg_addr(input logic [3:0] i);
    case (i)
      4'd0:    reg_addr = 8'h24;
      4'd1:    reg_addr = 8'h25;
      4'd2:    reg_addr = 8'h26;
      4'd3:    reg_addr = 8'h23;
      4'd4:    reg_addr = 8'h22;
      4'd5:    reg_addr = 8'h21;
      4'd6:    reg_addr = 8'h43;
      4'd7:    reg_addr = 8'h42;
      default: reg_addr = 8'h41;
    endcase
  endfunction

  // The wrap cycle is the tick; only IDLE acts on it, so ticks while busy are simply lost.
  assign tick = auto_en && (refresh_cnt == REFRESH_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      refresh_cnt <= '0;
      timeout_cnt <= '0;
      bus_req     <= 1'b0;
      bus_addr    <= '0;
      en          <= '0;
      data_out    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (!auto_en || tick) refresh_cnt <= '0;
      else                  refresh_cnt <= refresh_cnt + 1'b1;

      en   <= '0;
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        IDLE: begin
          if (start || tick) begin
            state       <= REQ;
            idx         <= '0;
            timeout_cnt <= '0;
            bus_req     <= 1'b1;
            bus_addr    <= reg_addr(4'd0);
            busy        <= 1'b1;
          end
        end
        REQ: begin
          if (bus_ack) begin
            state    <= WRITE;
            bus_req  <= 1'b0;
            data_out <= bus_rdata;
            en       <= 9'(1) << idx;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            state   <= ERR;
            bus_req <= 1'b0;
            err     <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (idx == 4'd8) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state       <= REQ;
            idx         <= idx + 4'd1;
            timeout_cnt <= '0;
            bus_req     <= 1'b1;
            bus_addr    <= reg_addr(idx + 4'd1);
          end
        end
        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Scoreboard bench: stimulus pushes expected strobe/done/err events with their cycle,
// a monitor pops and compares them whenever the sequencer presents one.
`timescale 1ns/1ps
module tb_rtc_read_sequencer;

  localparam int REFRESH = 20;
  localparam int TMO     = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       auto_en = 1'b0;
  logic       bus_ack = 1'b0;
  logic [7:0] bus_rdata = 8'h00;
  logic       bus_req;
  logic [7:0] bus_addr;
  logic [8:0] en;
  logic [7:0] data_out;
  logic       busy, done, err;

  rtc_read_sequencer #(.REFRESH_CYCLES(REFRESH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .auto_en(auto_en),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .en(en), .data_out(data_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    logic [11:0] code;   // {bus_req, err, done, en}
    logic [7:0]  data;
    bit          chk_data;
    int          idx;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;

  logic [7:0] addr_tab [9] = '{8'h24, 8'h25, 8'h26, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41};
  logic [7:0] byte_tab [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
  int         dly [9];
  logic [7:0] salt = 8'h00;
  bit         stray = 1'b0;
  int         rsp_cnt = 0;
  int         rsp_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int idx_of(input logic [7:0] a);
    for (int i = 0; i < 9; i++) if (addr_tab[i] == a) return i;
    return -1;
  endfunction

  // Expected events for a sequence launched at edge k; en for byte i appears dly[i]+1
  // cycles after its REQ entry, the next REQ one cycle later; a stalled byte errors after TMO.
  task automatic push_seq(input int k, input int cut);
    int t = k;
    ev_t e;
    for (int i = 0; i < 9; i++) begin
      if (dly[i] >= TMO) begin
        e.code = 12'h400; e.data = 8'h00; e.chk_data = 1'b0; e.idx = i; e.cyc = t + TMO;
        exp_q.push_back(e);
        return;
      end
      e.code = 12'(1) << i; e.data = byte_tab[i] ^ salt; e.chk_data = 1'b1;
      e.idx = i; e.cyc = t + dly[i] + 1;
      exp_q.push_back(e);
      t = e.cyc + 1;
      if (i == cut) return;
    end
    e.code = 12'h200; e.data = 8'h00; e.chk_data = 1'b0; e.idx = 9; e.cyc = t;
    exp_q.push_back(e);
  endtask

  task automatic run_seq(input int cut);
    start = 1'b1;
    push_seq(cyc + 1, cut);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("pending_events", 32'(exp_q.size()), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // RTC bus model: acks byte idx after dly[idx] extra REQ cycles, data from address.
  initial forever begin
    @(negedge clk);
    if (stray) begin
      bus_ack   = 1'b1;
      bus_rdata = 8'h5A;
    end else if (bus_req) begin
      rsp_i = idx_of(bus_addr);
      if (exp_q.size() > 0 && exp_q[0].chk_data)
        check("bus_addr", 32'(bus_addr), 32'(addr_tab[exp_q[0].idx]));
      if (rsp_i < 0) begin
        bus_ack = 1'b1; bus_rdata = 8'hEE;
      end else if (rsp_cnt == dly[rsp_i]) begin
        bus_ack = 1'b1; bus_rdata = byte_tab[rsp_i] ^ salt;
      end else begin
        bus_ack = 1'b0;
      end
      rsp_cnt++;
    end else begin
      bus_ack   = 1'b0;
      bus_rdata = 8'h00;
      rsp_cnt   = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (en != 9'h0 || done || err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'({bus_req, err, done, en}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe", 32'({bus_req, err, done, en}), 32'(mon_e.code));
        if (mon_e.chk_data) check("data_out", 32'(data_out), 32'(mon_e.data));
        check("timing", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    n_fail++;
    report();
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    for (int i = 0; i < 9; i++) dly[i] = 0;

    // Reset, with start held to show reset wins
    reset = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bus_req, bus_addr, en, data_out, busy, done, err}), 32'd0);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'({bus_req, bus_addr, en, data_out, busy, done, err}), 32'd0);

    // Full sequence, immediate acks, bytes 0x11..0x99
    salt = 8'h00;
    run_seq(-1);
    drain(200);

    // Stray acks in IDLE must not move anything
    stray = 1'b1;
    repeat (3) @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    check("data_hold", 32'(data_out), 32'h99);
    check("busy_idle", 32'(busy), 32'd0);

    // Ack delayed 3 cycles on idx 4
    salt = 8'hA5; dly[4] = 3;
    run_seq(-1);
    drain(200);
    dly[4] = 0;

    // No ack on idx 2: timeout abort
    salt = 8'h0F; dly[2] = 100;
    run_seq(-1);
    drain(200);
    dly[2] = 0;
    check("data_after_err", 32'(data_out), 32'h2D);

    // Reset during WRITE of idx 5
    salt = 8'h00;
    run_seq(5);
    n = 0;
    while (en !== 9'h020 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_write5", 32'(en), 32'h020);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_seq", 32'({bus_req, bus_addr, en, data_out, busy, done, err}), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    drain(5);
    salt = 8'h3C;
    run_seq(-1);
    drain(200);

    // start held high: back-to-back with one IDLE cycle between
    salt = 8'h00;
    c = cyc;
    start = 1'b1;
    push_seq(c + 1, -1);
    push_seq(c + 21, -1);
    repeat (39) @(negedge clk);
    start = 1'b0;
    drain(100);

    // Auto refresh: start on the tick cycle, a dropped tick while busy, next at tick+20
    salt = 8'h77;
    for (int i = 0; i < 9; i++) dly[i] = 2;
    c = cyc;
    auto_en = 1'b1;
    push_seq(c + 20, -1);
    push_seq(c + 60, -1);
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(300);
    auto_en = 1'b0;
    for (int i = 0; i < 9; i++) dly[i] = 0;
    repeat (5) @(negedge clk);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    report();
    $finish;
  end

endmodule
